// File: rtl/lcd_timing_gen.sv
// -----------------------------------------------------------------------------
// lcd_timing_gen
//   RGB-LCD / VGA timing generator. Produces hsync, vsync, data enable and
//   0-based active-area coordinates for any panel geometry and sync polarity.
//   Every output is a flop, one clock behind the internal position counters.
//   A run request (en) may be dropped at any time; the generator then finishes
//   the current frame before going idle, so the panel never sees a partial
//   frame.
//
//   Optional feature macro: LCD_TPG_EN
//     defined   -> rgb carries an 8-bar vertical colour test pattern
//     undefined -> rgb is tied to 16'h0000 and no pattern logic exists
//
// Ports
//   clk          in   pixel clock
//   rst          in   asynchronous, active-high reset
//   en           in   run request, sampled every clk
//   hsync        out  horizontal sync, active level HS_POL
//   vsync        out  vertical sync, active level VS_POL
//   de           out  data enable, high inside the active window
//   x, y         out  active column / row (0 when de=0), CW bits
//   line_start   out  1-clk pulse at h=0 of every line
//   frame_start  out  1-clk pulse at h=0, v=0
//   running      out  high while running or draining the last frame
//   rgb          out  RGB565 test pattern (see LCD_TPG_EN)
// -----------------------------------------------------------------------------
module lcd_timing_gen #(
    parameter int H_SYNC   = 77,
    parameter int H_BP     = 53,
    parameter int H_ACTIVE = 480,
    parameter int H_FP     = 24,
    parameter int V_SYNC   = 2,
    parameter int V_BP     = 33,
    parameter int V_ACTIVE = 272,
    parameter int V_FP     = 10,
    parameter int CW       = 11,
    parameter bit HS_POL   = 1'b1,
    parameter bit VS_POL   = 1'b1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          en,
    output logic          hsync,
    output logic          vsync,
    output logic          de,
    output logic [CW-1:0] x,
    output logic [CW-1:0] y,
    output logic          line_start,
    output logic          frame_start,
    output logic          running,
    output logic [15:0]   rgb
);

    localparam int H_TOTAL = H_SYNC + H_BP + H_ACTIVE + H_FP;
    localparam int V_TOTAL = V_SYNC + V_BP + V_ACTIVE + V_FP;

    localparam logic [CW-1:0] H_LAST      = CW'(H_TOTAL - 1);
    localparam logic [CW-1:0] V_LAST      = CW'(V_TOTAL - 1);
    localparam logic [CW-1:0] H_SYNC_END  = CW'(H_SYNC);
    localparam logic [CW-1:0] V_SYNC_END  = CW'(V_SYNC);
    localparam logic [CW-1:0] H_ACT_START = CW'(H_SYNC + H_BP);
    localparam logic [CW-1:0] V_ACT_START = CW'(V_SYNC + V_BP);
    localparam logic [CW-1:0] H_ACT_END   = CW'(H_SYNC + H_BP + H_ACTIVE);
    localparam logic [CW-1:0] V_ACT_END   = CW'(V_SYNC + V_BP + V_ACTIVE);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RUN,
        ST_STOPPING
    } state_t;

    state_t        state_reg, state_next;
    logic [CW-1:0] h_pos_reg, h_pos_next;
    logic [CW-1:0] v_pos_reg, v_pos_next;

    logic          hsync_reg, hsync_next;
    logic          vsync_reg, vsync_next;
    logic          de_reg, de_next;
    logic [CW-1:0] x_reg, x_next;
    logic [CW-1:0] y_reg, y_next;
    logic          line_start_reg, line_start_next;
    logic          frame_start_reg, frame_start_next;
    logic          running_reg, running_next;

    logic h_last, v_last, frame_last, active;
    logic h_act, v_act;

    // Next state and counter update
    always_comb begin
        state_next = state_reg;
        h_pos_next = h_pos_reg;
        v_pos_next = v_pos_reg;
        h_last     = (h_pos_reg == H_LAST);
        v_last     = (v_pos_reg == V_LAST);
        frame_last = h_last & v_last;

        case (state_reg)
            ST_IDLE:     if (en) state_next = ST_RUN;
            ST_RUN:      if (!en) state_next = ST_STOPPING;
            ST_STOPPING: begin
                // A request on the final cycle keeps the frame stream seamless.
                if (en)
                    state_next = ST_RUN;
                else if (frame_last)
                    state_next = ST_IDLE;
            end
            default:     state_next = ST_IDLE;
        endcase

        // Counters hold at 0 when idle; the natural wrap on the last cycle of
        // a frame already leaves them at 0 when going idle.
        if (state_reg == ST_IDLE) begin
            h_pos_next = '0;
            v_pos_next = '0;
        end else if (h_last) begin
            h_pos_next = '0;
            v_pos_next = v_last ? '0 : v_pos_reg + 1'b1;
        end else begin
            h_pos_next = h_pos_reg + 1'b1;
        end
    end

    // Decode of the current position into the values the output flops take
    always_comb begin
        active = (state_reg != ST_IDLE);
        h_act  = (h_pos_reg >= H_ACT_START) && (h_pos_reg < H_ACT_END);
        v_act  = (v_pos_reg >= V_ACT_START) && (v_pos_reg < V_ACT_END);

        hsync_next       = (active && (h_pos_reg < H_SYNC_END)) ? HS_POL : ~HS_POL;
        vsync_next       = (active && (v_pos_reg < V_SYNC_END)) ? VS_POL : ~VS_POL;
        de_next          = active & h_act & v_act;
        x_next           = de_next ? h_pos_reg - H_ACT_START : '0;
        y_next           = de_next ? v_pos_reg - V_ACT_START : '0;
        line_start_next  = active && (h_pos_reg == '0);
        frame_start_next = line_start_next && (v_pos_reg == '0);
        running_next     = (state_next != ST_IDLE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg       <= ST_IDLE;
            h_pos_reg       <= '0;
            v_pos_reg       <= '0;
            hsync_reg       <= ~HS_POL;
            vsync_reg       <= ~VS_POL;
            de_reg          <= 1'b0;
            x_reg           <= '0;
            y_reg           <= '0;
            line_start_reg  <= 1'b0;
            frame_start_reg <= 1'b0;
            running_reg     <= 1'b0;
        end else begin
            state_reg       <= state_next;
            h_pos_reg       <= h_pos_next;
            v_pos_reg       <= v_pos_next;
            hsync_reg       <= hsync_next;
            vsync_reg       <= vsync_next;
            de_reg          <= de_next;
            x_reg           <= x_next;
            y_reg           <= y_next;
            line_start_reg  <= line_start_next;
            frame_start_reg <= frame_start_next;
            running_reg     <= running_next;
        end
    end

    assign hsync       = hsync_reg;
    assign vsync       = vsync_reg;
    assign de          = de_reg;
    assign x           = x_reg;
    assign y           = y_reg;
    assign line_start  = line_start_reg;
    assign frame_start = frame_start_reg;
    assign running     = running_reg;

`ifdef LCD_TPG_EN
    // Bar index = x*8/H_ACTIVE, built as a thermometer of x*8 >= k*H_ACTIVE
    // for k = 1..7 so no divider is needed.
    logic [CW+3:0] x_scaled;
    logic [6:0]    bar_thr;
    logic [2:0]    bar_idx;
    logic [15:0]   bar_rgb;
    logic [15:0]   rgb_reg, rgb_next;

    assign x_scaled = {1'b0, x_next, 3'b000};

    generate
        for (genvar gi = 1; gi < 8; gi++) begin : g_bar_thr
            assign bar_thr[gi-1] = (x_scaled >= (CW+4)'(gi * H_ACTIVE));
        end
    endgenerate

    always_comb begin
        bar_idx = '0;
        for (int i = 0; i < 7; i++)
            bar_idx = bar_idx + {2'b00, bar_thr[i]};

        case (bar_idx)
            3'd0:    bar_rgb = 16'hFFFF;  // white
            3'd1:    bar_rgb = 16'hFFE0;  // yellow
            3'd2:    bar_rgb = 16'h07FF;  // cyan
            3'd3:    bar_rgb = 16'h07E0;  // green
            3'd4:    bar_rgb = 16'hF81F;  // magenta
            3'd5:    bar_rgb = 16'hF800;  // red
            3'd6:    bar_rgb = 16'h001F;  // blue
            default: bar_rgb = 16'h0000;  // black
        endcase

        rgb_next = de_next ? bar_rgb : 16'h0000;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            rgb_reg <= 16'h0000;
        else
            rgb_reg <= rgb_next;
    end

    assign rgb = rgb_reg;
`else
    assign rgb = 16'h0000;
`endif

endmodule

// File: tb/tb_lcd_timing_gen.sv
// -----------------------------------------------------------------------------
// tb_lcd_timing_gen
//   Two generators share clk/rst/en:
//     dut0: H 2/1/4/1 (H_TOTAL=8),  V 1/1/3/1 (V_TOTAL=6), positive syncs
//     dut1: H 2/1/8/1 (H_TOTAL=12), same V, negative syncs
//   A reference model tracks each generator as a linear frame index plus a
//   run mode, derives the expected outputs with div/mod arithmetic and pushes
//   them into a per-DUT queue; a monitor pops and compares every cycle.
// -----------------------------------------------------------------------------
module tb_lcd_timing_gen;

    typedef struct {
        logic        hs;
        logic        vs;
        logic        de;
        logic [3:0]  x;
        logic [3:0]  y;
        logic        ls;
        logic        fs;
        logic        run;
        logic [15:0] rgb;
    } exp_t;

    logic clk, rst, en;

    logic        hs0, vs0, de0, ls0, fs0, run0;
    logic [3:0]  x0, y0;
    logic [15:0] rgb0;
    logic        hs1, vs1, de1, ls1, fs1, run1;
    logic [3:0]  x1, y1;
    logic [15:0] rgb1;

    lcd_timing_gen #(
        .H_SYNC(2), .H_BP(1), .H_ACTIVE(4), .H_FP(1),
        .V_SYNC(1), .V_BP(1), .V_ACTIVE(3), .V_FP(1),
        .CW(4), .HS_POL(1'b1), .VS_POL(1'b1)
    ) dut0 (
        .clk(clk), .rst(rst), .en(en),
        .hsync(hs0), .vsync(vs0), .de(de0), .x(x0), .y(y0),
        .line_start(ls0), .frame_start(fs0), .running(run0), .rgb(rgb0)
    );

    lcd_timing_gen #(
        .H_SYNC(2), .H_BP(1), .H_ACTIVE(8), .H_FP(1),
        .V_SYNC(1), .V_BP(1), .V_ACTIVE(3), .V_FP(1),
        .CW(4), .HS_POL(1'b0), .VS_POL(1'b0)
    ) dut1 (
        .clk(clk), .rst(rst), .en(en),
        .hsync(hs1), .vsync(vs1), .de(de1), .x(x1), .y(y1),
        .line_start(ls1), .frame_start(fs1), .running(run1), .rgb(rgb1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Geometry of the two instances (vertical timing is shared)
    int          ht   [2] = '{8, 12};
    int          hact [2] = '{4, 8};
    logic        pol  [2] = '{1'b1, 1'b0};
    logic [15:0] bars [8] = '{16'hFFFF, 16'hFFE0, 16'h07FF, 16'h07E0,
                              16'hF81F, 16'hF800, 16'h001F, 16'h0000};

    // Model state: mode 0=idle 1=run 2=stopping; idx = v*H_TOTAL + h
    int mode [2];
    int idx  [2];
    exp_t q0[$];
    exp_t q1[$];

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    int last_fs  = -1000, prev_fs = -2000;
    int last_ls  = -1000, prev_ls = -2000;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic exp_t predict(input int g, input int m, input int p);
        exp_t e;
        int h, v;
        logic ha, va;
        h = p % ht[g];
        v = p / ht[g];
        e.hs = ~pol[g]; e.vs = ~pol[g]; e.de = 1'b0; e.x = '0; e.y = '0;
        e.ls = 1'b0; e.fs = 1'b0; e.run = 1'b0; e.rgb = 16'h0000;
        if (m != 0) begin
            e.hs = (h < 2) ? pol[g] : ~pol[g];
            e.vs = (v < 1) ? pol[g] : ~pol[g];
            ha   = (h >= 3) && (h < 3 + hact[g]);
            va   = (v >= 2) && (v < 5);
            e.de = ha && va;
            if (e.de) begin
                e.x = 4'(h - 3);
                e.y = 4'(v - 2);
`ifdef LCD_TPG_EN
                e.rgb = bars[((h - 3) * 8) / hact[g]];
`endif
            end
            e.ls = (h == 0);
            e.fs = (p == 0);
        end
        return e;
    endfunction

    // Reference model: expected outputs after each edge
    always @(posedge clk) begin
        exp_t e;
        int   f;
        cyc++;
        for (int g = 0; g < 2; g++) begin
            f = ht[g] * 6;
            if (rst) begin
                mode[g] = 0;
                idx[g]  = 0;
                e = predict(g, 0, 0);
            end else begin
                e = predict(g, mode[g], idx[g]);
                case (mode[g])
                    0: if (en) mode[g] = 1;
                    1: begin
                        idx[g] = (idx[g] + 1) % f;
                        if (!en) mode[g] = 2;
                    end
                    default: begin
                        if (en) mode[g] = 1;
                        else if (idx[g] == f - 1) mode[g] = 0;
                        idx[g] = (idx[g] + 1) % f;
                    end
                endcase
                e.run = (mode[g] != 0);
            end
            if (g == 0) q0.push_back(e);
            else        q1.push_back(e);
        end
    end

    task automatic cmp_all(input string tag, input exp_t e,
                           input logic hs, input logic vs, input logic de,
                           input logic [3:0] x, input logic [3:0] y,
                           input logic ls, input logic fs, input logic run,
                           input logic [15:0] rgb);
        check({tag, ".hsync"},       32'(hs),  32'(e.hs));
        check({tag, ".vsync"},       32'(vs),  32'(e.vs));
        check({tag, ".de"},          32'(de),  32'(e.de));
        check({tag, ".x"},           32'(x),   32'(e.x));
        check({tag, ".y"},           32'(y),   32'(e.y));
        check({tag, ".line_start"},  32'(ls),  32'(e.ls));
        check({tag, ".frame_start"}, 32'(fs),  32'(e.fs));
        check({tag, ".running"},     32'(run), 32'(e.run));
        check({tag, ".rgb"},         32'(rgb), 32'(e.rgb));
    endtask

    // Monitor: sample 1 time unit after each active edge
    always @(posedge clk) begin
        exp_t e;
        #1;
        if (q0.size() > 0) begin
            e = q0.pop_front();
            cmp_all("dut0", e, hs0, vs0, de0, x0, y0, ls0, fs0, run0, rgb0);
        end
        if (q1.size() > 0) begin
            e = q1.pop_front();
            cmp_all("dut1", e, hs1, vs1, de1, x1, y1, ls1, fs1, run1, rgb1);
        end
        if (fs0) begin prev_fs = last_fs; last_fs = cyc; end
        if (ls0) begin prev_ls = last_ls; last_ls = cyc; end
    end

    task automatic wait_idx(input int target);
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (idx[0] == target) return;
        end
        check("wait_idx_timeout", 32'(idx[0]), 32'(target));
    endtask

    // Release reset at a negedge and measure edges until frame_start
    task automatic release_and_check(input string name);
        int c0;
        bit seen;
        rst  = 1'b0;
        c0   = cyc;
        seen = 0;
        for (int i = 0; i < 20 && !seen; i++) begin
            @(negedge clk);
            if (fs0) seen = 1;
        end
        check(name, 32'(cyc - c0), 32'd2);
    endtask

    initial begin
        rst = 1'b1;
        en  = 1'b1;

        // 1: reset state with en high
        repeat (3) @(negedge clk);
        check("rst.hsync0",   32'(hs0),  32'd0);
        check("rst.vsync0",   32'(vs0),  32'd0);
        check("rst.hsync1",   32'(hs1),  32'd1);
        check("rst.running0", 32'(run0), 32'd0);
        check("rst.de0",      32'(de0),  32'd0);
        release_and_check("start_latency");
        $display("phase 1: reset and start");

        // 2: free run three frames
        repeat (3 * 48) @(negedge clk);
        check("fs_period", 32'(last_fs - prev_fs), 32'd48);
        check("ls_period", 32'(last_ls - prev_ls), 32'd8);
        $display("phase 2: free run");

        // 3: drop en at h=5, v=2 -> drain to end of frame then idle
        wait_idx(2 * 8 + 5);
        en = 1'b0;
        repeat (40) @(negedge clk);
        check("stop.running0", 32'(run0), 32'd0);
        check("stop.de0",      32'(de0),  32'd0);
        $display("phase 3: stop on frame boundary");

        // 4: restart, drop en, reassert at h=3, v=4 while stopping
        en = 1'b1;
        wait_idx(10);
        en = 1'b0;
        wait_idx(4 * 8 + 3);
        en = 1'b1;
        repeat (20) @(negedge clk);
        check("resume_fs_period", 32'(last_fs - prev_fs), 32'd48);
        $display("phase 4: resume while stopping");

        // 5: random run requests
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            en = ($urandom_range(0, 7) != 0);
        end
        en = 1'b1;
        repeat (3) @(negedge clk);
        $display("phase 5: random en");

        // 6: asynchronous reset mid-frame at h=4, v=3
        wait_idx(3 * 8 + 4);
        #2 rst = 1'b1;
        #1;
        check("arst.hsync0",   32'(hs0),  32'd0);
        check("arst.vsync0",   32'(vs0),  32'd0);
        check("arst.hsync1",   32'(hs1),  32'd1);
        check("arst.vsync1",   32'(vs1),  32'd1);
        check("arst.running0", 32'(run0), 32'd0);
        check("arst.x0",       32'(x0),   32'd0);
        @(negedge clk);
        release_and_check("restart_latency");
        repeat (100) @(negedge clk);
        $display("phase 6: async reset and restart");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected $finish");
        $fatal(1, "watchdog");
    end

endmodule
